// File: rtl/core_axi_pkg.sv
// core_axi_pkg
//   Shared types and constants for the core-to-AXI4 single-beat master.
//   - master_state_t : FSM state encoding (3 bits, 6 states)
//   - AXI_RESP_*     : AXI response codes used when judging BRESP/RRESP
//   - resp_is_error  : true for any response other than OKAY
package core_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_WRITE_RESP = 3'd2,
    ST_READ       = 3'd3,
    ST_READ_RESP  = 3'd4,
    ST_DONE       = 3'd5
  } master_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/core_mem_to_axi4_master.sv
// core_mem_to_axi4_master
//   Turns a core's single-beat req/ack memory port into single-beat AXI4
//   write (AW/W/B) or read (AR/R) transactions, one outstanding at a time.
//   The request payload is latched when accepted; completion is a one-cycle
//   core_ack pulse with core_err qualifying it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req/we/addr/wdata/wstrb  request from the core (held until ack)
//   core_rdata/ack/err/busy    completion and status back to the core
//   M_AXI_AW*, M_AXI_W*        write address / write data channels
//   M_AXI_B*                   write response channel
//   M_AXI_AR*, M_AXI_R*        read address / read data channels
//
// All outputs come straight from registers.
module core_mem_to_axi4_master
  import core_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    core_req,
  input  logic                    core_we,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_wstrb,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  output logic                    core_ack,
  output logic                    core_err,
  output logic                    core_busy,

  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ID_WIDTH-1:0] ID_CONST = ID_WIDTH'(AXI_ID);

  master_state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg,   wdata_next;
  logic [STRB_WIDTH-1:0] wstrb_reg,   wstrb_next;
  logic [DATA_WIDTH-1:0] rdata_reg,   rdata_next;
  logic                  awvalid_reg, awvalid_next;
  logic                  wvalid_reg,  wvalid_next;
  logic                  aw_done_reg, aw_done_next;
  logic                  w_done_reg,  w_done_next;
  logic                  bready_reg,  bready_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  rready_reg,  rready_next;
  logic                  ack_reg,     ack_next;
  logic                  err_reg,     err_next;
  logic                  busy_reg,    busy_next;

  // Handshakes are only ever qualified by our own registered VALID/READY,
  // so stray READY/VALID from the interconnect cannot advance the FSM.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid_reg & M_AXI_AWREADY;
  assign w_hs  = wvalid_reg  & M_AXI_WREADY;
  assign b_hs  = bready_reg  & M_AXI_BVALID;
  assign ar_hs = arvalid_reg & M_AXI_ARREADY;
  assign r_hs  = rready_reg  & M_AXI_RVALID;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rdata_reg   <= rdata_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rdata_next   = rdata_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    // ack/err are pulses: they are only raised on the edge entering DONE
    ack_next     = 1'b0;
    err_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (core_req) begin
          addr_next  = core_addr;
          wdata_next = core_wdata;
          wstrb_next = core_wstrb;
          if (core_we) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = ST_WRITE;
          end else begin
            arvalid_next = 1'b1;
            state_next   = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        // Each channel drops its VALID on its own handshake; the phase ends
        // once both have completed, in whichever order they arrive.
        if (aw_hs) awvalid_next = 1'b0;
        if (w_hs)  wvalid_next  = 1'b0;
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg  | w_hs;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          bready_next  = 1'b1;
          state_next   = ST_WRITE_RESP;
        end
      end

      ST_WRITE_RESP: begin
        if (b_hs) begin
          bready_next = 1'b0;
          ack_next    = 1'b1;
          err_next    = resp_is_error(M_AXI_BRESP) | (M_AXI_BID != ID_CONST);
          state_next  = ST_DONE;
        end
      end

      ST_READ: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = ST_READ_RESP;
        end
      end

      ST_READ_RESP: begin
        if (r_hs) begin
          rdata_next  = M_AXI_RDATA;
          rready_next = 1'b0;
          ack_next    = 1'b1;
          err_next    = resp_is_error(M_AXI_RRESP) | (M_AXI_RID != ID_CONST);
          state_next  = ST_DONE;
        end
      end

      ST_DONE: begin
        // core_req is deliberately not looked at here: the core is still
        // presenting the request that is being retired this cycle.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign core_rdata    = rdata_reg;
  assign core_ack      = ack_reg;
  assign core_err      = err_reg;
  assign core_busy     = busy_reg;

  assign M_AXI_AWID    = ID_CONST;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARID    = ID_CONST;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_core_mem_to_axi4_master.sv
// tb_core_mem_to_axi4_master
//   Directed, cycle-exact bench for core_mem_to_axi4_master. The bench plays
//   the AXI slave side by hand each cycle; a small byte-strobed word memory
//   keeps what was written so later reads can return it.
module tb_core_mem_to_axi4_master;
  import core_axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 4;
  localparam logic [IW-1:0] ID = 4'd0;

  logic          clk;
  logic          rst_n;
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [SW-1:0] core_wstrb;
  logic [DW-1:0] core_rdata;
  logic          core_ack;
  logic          core_err;
  logic          core_busy;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  core_mem_to_axi4_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err),
    .core_busy(core_busy),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; afterwards outputs are stable and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = AXI_RESP_OKAY; bid = ID;
    arready = 1'b0;
    rvalid = 1'b0; rresp = AXI_RESP_OKAY; rid = ID; rdata = '0;
  endtask

  task automatic core_request(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d; core_wstrb = s;
  endtask

  // Slave memory: store the W beat seen on the bus under its byte strobes.
  task automatic mem_store();
    logic [DW-1:0] w;
    w = mem.exists(awaddr) ? mem[awaddr] : '0;
    for (int b = 0; b < SW; b++)
      if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
    mem[awaddr] = w;
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
    slave_idle();

    // ---------------- reset state ----------------
    #3;
    chk("rst_busy", core_busy, 1'b0);
    chk("rst_ack", core_ack, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_ids", {awid, arid}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- 1: minimum-latency write ----------------
    core_request(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();                                   // T1
    chk("w1_awvalid", awvalid, 1'b1);
    chk("w1_wvalid", wvalid, 1'b1);
    chk("w1_awaddr", awaddr, 32'h100);
    chk("w1_wdata", wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", wstrb, 4'hF);
    chk("w1_busy", core_busy, 1'b1);
    mem_store();
    bvalid = 1'b1; bresp = AXI_RESP_OKAY; bid = ID;
    tick();                                   // T2
    chk("w1_valids_drop", {awvalid, wvalid}, 2'b00);
    chk("w1_bready", bready, 1'b1);
    chk("w1_no_early_ack", core_ack, 1'b0);
    tick();                                   // T3
    chk("w1_ack", core_ack, 1'b1);
    chk("w1_err", core_err, 1'b0);
    chk("w1_bready_clr", bready, 1'b0);
    $display("txn write addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h100, 32'hDEAD_BEEF, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();
    chk("w1_ack_pulse", core_ack, 1'b0);
    chk("w1_idle", core_busy, 1'b0);

    // ---------------- 2: split write handshake ----------------
    core_request(1'b1, 32'h200, 32'h1234_5678, 4'h3);
    wready = 1'b1;
    tick();                                   // c1: W handshake this cycle
    chk("w2_both_valid", {awvalid, wvalid}, 2'b11);
    mem_store();
    tick();                                   // c2
    chk("w2_wvalid_drop", wvalid, 1'b0);
    chk("w2_awvalid_hold", awvalid, 1'b1);
    chk("w2_bready_wait", bready, 1'b0);
    wready = 1'b0;
    tick();                                   // c3
    chk("w2_awvalid_hold2", awvalid, 1'b1);
    chk("w2_wvalid_low", wvalid, 1'b0);
    awready = 1'b1;
    tick();                                   // c4
    chk("w2_awvalid_drop", awvalid, 1'b0);
    chk("w2_bready", bready, 1'b1);
    awready = 1'b0;
    bvalid = 1'b1;                            // held high beyond the handshake
    tick();                                   // c5
    chk("w2_ack", core_ack, 1'b1);
    chk("w2_err", core_err, 1'b0);
    chk("w2_bready_clr", bready, 1'b0);
    $display("txn write addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h200, 32'h1234_5678, core_ack, core_err);
    core_req = 1'b0;
    tick();                                   // c6
    chk("w2_single_ack", core_ack, 1'b0);
    chk("w2_no_second_b", bready, 1'b0);
    tick();                                   // c7
    chk("w2_still_idle", {core_ack, bready, core_busy}, 3'b000);
    slave_idle();

    // ---------------- 3: read with slow AR and R ----------------
    core_request(1'b0, 32'h100, 32'h0, 4'h0);
    tick();                                   // c1
    chk("r3_arvalid", arvalid, 1'b1);
    chk("r3_araddr", araddr, 32'h100);
    chk("r3_no_aw", awvalid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("r3_arvalid_hold", arvalid, 1'b1);
    end
    arready = 1'b1;
    tick();                                   // c4
    chk("r3_arvalid_drop", arvalid, 1'b0);
    chk("r3_rready", rready, 1'b1);
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("r3_rready_wait", {rready, core_ack}, 2'b10);
    end
    rvalid = 1'b1; rdata = mem_rd(32'h100); rresp = AXI_RESP_OKAY; rid = ID;
    tick();
    chk("r3_ack", core_ack, 1'b1);
    chk("r3_err", core_err, 1'b0);
    chk("r3_rdata", core_rdata, 32'hDEAD_BEEF);
    chk("r3_rready_clr", rready, 1'b0);
    $display("txn read  addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h100, core_rdata, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();
    chk("r3_ack_pulse", core_ack, 1'b0);

    // ---------------- 4a: read with SLVERR ----------------
    core_request(1'b0, 32'h200, 32'h0, 4'h0);
    arready = 1'b1;
    rvalid = 1'b1; rdata = mem_rd(32'h200); rresp = AXI_RESP_SLVERR; rid = ID;
    tick();                                   // c1: stray RVALID ignored
    chk("e4_rready_low", rready, 1'b0);
    tick();                                   // c2
    chk("e4_rready", rready, 1'b1);
    tick();                                   // c3
    chk("e4_ack", core_ack, 1'b1);
    chk("e4_err", core_err, 1'b1);
    chk("e4_rdata", core_rdata, 32'h0000_5678);
    $display("txn read  addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h200, core_rdata, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();
    chk("e4_err_pulse", {core_ack, core_err}, 2'b00);

    // ---------------- 4b: write with wrong BID ----------------
    core_request(1'b1, 32'h300, 32'hA5A5_A5A5, 4'hF);
    awready = 1'b1; wready = 1'b1;
    bvalid = 1'b1; bresp = AXI_RESP_OKAY; bid = ID + 4'd1;
    tick();
    mem_store();
    tick();
    tick();
    chk("e5_ack", core_ack, 1'b1);
    chk("e5_err", core_err, 1'b1);
    chk("e5_rdata_kept", core_rdata, 32'h0000_5678);
    $display("txn write addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h300, 32'hA5A5_A5A5, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();

    // ---------------- 5: back-to-back with core_req held ----------------
    core_request(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF);
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b1; bresp = AXI_RESP_OKAY; bid = ID;
    tick();                                   // c1
    mem_store();
    tick();                                   // c2
    tick();                                   // c3 DONE
    chk("b6_ack_w", core_ack, 1'b1);
    $display("txn write addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h4, 32'hCAFE_F00D, core_ack, core_err);
    core_request(1'b0, 32'h4, 32'h0, 4'h0);   // still requesting
    tick();                                   // c4 IDLE
    chk("b6_no_dup", {awvalid, wvalid, arvalid, bready, core_ack}, 5'b0);
    chk("b6_idle", core_busy, 1'b0);
    tick();                                   // c5
    chk("b6_arvalid", arvalid, 1'b1);
    chk("b6_araddr", araddr, 32'h4);
    chk("b6_no_aw", awvalid, 1'b0);
    rvalid = 1'b1; rdata = mem_rd(32'h4); rresp = AXI_RESP_OKAY; rid = ID;
    tick();                                   // c6
    chk("b6_rready", rready, 1'b1);
    tick();                                   // c7
    chk("b6_ack_r", core_ack, 1'b1);
    chk("b6_rdata", core_rdata, 32'hCAFE_F00D);
    chk("b6_err", core_err, 1'b0);
    $display("txn read  addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h4, core_rdata, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();

    // ---------------- 6: reset during WRITE_RESP ----------------
    core_request(1'b1, 32'h8, 32'h1122_3344, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    tick();
    chk("x7_bready_pre", bready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;                                       // no clock edge in between
    chk("x7_bready_async", bready, 1'b0);
    chk("x7_busy_async", core_busy, 1'b0);
    chk("x7_valids_async", {awvalid, wvalid, arvalid, rready, core_ack}, 5'b0);
    core_req = 1'b0; slave_idle();
    tick();
    rst_n = 1'b1;
    tick();
    chk("x7_rdata_cleared", core_rdata, 32'h0);
    core_request(1'b0, 32'h4, 32'h0, 4'h0);
    arready = 1'b1;
    rvalid = 1'b1; rdata = mem_rd(32'h4); rresp = AXI_RESP_OKAY; rid = ID;
    tick();
    chk("x7_arvalid", arvalid, 1'b1);
    tick();
    tick();
    chk("x7_ack", core_ack, 1'b1);
    chk("x7_err", core_err, 1'b0);
    chk("x7_rdata", core_rdata, 32'hCAFE_F00D);
    $display("txn read  addr=0x%08h data=0x%08h ack=%0b err=%0b", 32'h4, core_rdata, core_ack, core_err);
    core_req = 1'b0; slave_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core_mem_to_axi4_master.md
Name: core_mem_to_axi4_master

Overview:
- Upstream neighbour of the AXI4-to-Wishbone slave bridge.
- Converts a processor core's simple single-beat memory port (req/ack) into single-beat AXI4 write (AW/W/B) or read (AR/R) transactions.
- One outstanding transaction at a time. No bursts. The request payload is latched at acceptance, and the result is returned as a one-cycle ack pulse.
- Sits between the core under test and the AXI interconnect/bridge in the processor CI harness.

Parameters:
- ADDR_WIDTH, 32, width of core_addr and M_AXI_AWADDR/M_AXI_ARADDR.
- DATA_WIDTH, 32, data width; must be a multiple of 8. Strobe width is DATA_WIDTH/8.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on AWID/ARID and expected on BID/RID.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  request valid; held with a stable payload until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_WIDTH  byte address.
- core_wdata  in  DATA_WIDTH  write data.
- core_wstrb  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- core_rdata  out  DATA_WIDTH  read data; valid while core_ack=1.
- core_ack  out  1  one-cycle completion pulse.
- core_err  out  1  error flag; qualified by core_ack.
- core_busy  out  1  high whenever the FSM is not IDLE.
- M_AXI_AWID / AWADDR / AWVALID  out  ID_WIDTH / ADDR_WIDTH / 1  write address channel.
- M_AXI_AWREADY  in  1  write address channel.
- M_AXI_WDATA / WSTRB / WVALID  out  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel.
- M_AXI_WREADY  in  1  write data channel.
- M_AXI_BID / BRESP / BVALID  in  ID_WIDTH / 2 / 1  write response channel.
- M_AXI_BREADY  out  1  write response channel.
- M_AXI_ARID / ARADDR / ARVALID  out  ID_WIDTH / ADDR_WIDTH / 1  read address channel.
- M_AXI_ARREADY  in  1  read address channel.
- M_AXI_RID / RDATA / RRESP / RVALID  in  ID_WIDTH / DATA_WIDTH / 2 / 1  read data channel.
- M_AXI_RREADY  out  1  read data channel.

Behaviour:
- Registers and outputs:
  - All outputs are registered.
  - On rst_n=0, every VALID/READY, core_ack, core_err and core_busy clears to 0 asynchronously, and all data/address registers clear to 0.
  - Reset mid-transaction drops VALIDs immediately. This is accepted; the interconnect is reset together with this block.
- FSM states: IDLE, WRITE, WRITE_RESP, READ, READ_RESP, DONE.
- IDLE:
  - If core_req=1, latch addr, wdata, wstrb and we.
  - If we=1, go to WRITE, setting AWVALID=WVALID=1 at the same edge. If we=0, go to READ, setting ARVALID=1.
  - First VALID appears 1 cycle after core_req is sampled.
- WRITE:
  - AWVALID and WVALID are asserted together. This is mandatory: the downstream bridge accepts only when both are valid.
  - Each VALID is held until its own handshake (VALID&READY at the edge), then cleared. Per-channel done flags track this.
  - Handshakes may occur in the same or different cycles.
  - When both are done, go to WRITE_RESP with BREADY=1.
  - A VALID is never dropped before its READY.
- WRITE_RESP: on BVALID&BREADY, clear BREADY and go to DONE. Set err = (BRESP!=2'b00) | (BID!=AXI_ID).
- READ: ARVALID is held until ARREADY, then go to READ_RESP with RREADY=1.
- READ_RESP: on RVALID&RREADY, capture RDATA into core_rdata, clear RREADY, go to DONE. Set err = (RRESP!=2'b00) | (RID!=AXI_ID).
- DONE:
  - core_ack=1 and core_err=err for exactly one cycle, then go to IDLE.
  - core_req is not sampled in DONE. This prevents re-issuing the request the core is just retiring.
  - A new request is accepted at the earliest in the IDLE cycle after DONE.
- Response data:
  - core_rdata holds the last read value until the next read completes.
  - For writes, core_rdata is unchanged.
- Minimum latency (READY tied high, same-cycle response): req sampled at T0, VALID at T1, response handshake at T2, ack at T3.
- Spurious inputs:
  - BVALID or RVALID outside its response state is ignored; READY stays low.
  - AWREADY/WREADY/ARREADY while the matching VALID is low have no effect.
- Constant outputs: AWID = ARID = AXI_ID.

Decomposition:
- Package core_axi_pkg holds:
  - enum master_state_t (6 states, 3-bit).
  - Constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
- No sub-module is needed. The per-channel AW/W done tracking is inline logic.

Test Plan:
- Write with AWREADY/WREADY high and BRESP=OKAY: addr 0x100, wdata 0xDEADBEEF, wstrb 0xF -> AW/W valid together at T1; ack at T3 with err=0; Wishbone memory model word 0x100 = 0xDEADBEEF.
- Split write handshake: WREADY 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID is held until AWREADY, exactly one B is accepted, and ack pulses once.
- Read of 0x100 through the bridge and Wishbone memory with a 3-cycle Wishbone wait -> core_rdata = 0xDEADBEEF at ack; err=0; ARVALID is held until ARREADY.
- Error responses: RRESP=2'b10 -> ack with err=1. BID=AXI_ID+1 with OKAY -> ack with err=1.
- Back-to-back: core_req held high across two requests (write 0x4, then read 0x4) -> no duplicate transaction in DONE; the second request starts in the cycle after DONE; read returns the written data.
- Reset asserted during WRITE_RESP -> all VALID/READY outputs, core_ack and core_busy go 0 immediately (asynchronously); after release, a fresh read completes normally.
